// File: rtl/des_multi_pkg.sv
// ============================================================================
// Module : des_multi_pkg
// Brief  : Shared opcodes, state encodings and width helpers for the
//          multi-core DES search controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package des_multi_pkg;

  localparam logic [3:0] c_op_load_region = 4'd1;
  localparam logic [3:0] c_op_start       = 4'd2;
  localparam logic [3:0] c_op_test        = 4'd3;
  localparam logic [3:0] c_op_restart     = 4'd4;
  localparam logic [3:0] c_op_start_all   = 4'd5;
  localparam logic [3:0] c_op_restart_all = 4'd6;

  localparam int c_reject_bit = 31;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    TEST  = 3'd4
  } core_state_e;

  typedef enum logic [0:0] {
    C_IDLE = 1'b0,
    C_ACK  = 1'b1
  } cmd_state_e;

  // Core counter width for a given region width.
  function automatic int des_cw(input int n);
    return 64 - n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/des_core_channel.sv
// ============================================================================
// Module : des_core_channel
// Brief  : Per-core control channel: state machine, region register, result
//          capture and pending flag for one DES search core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_core_channel
  import des_multi_pkg::*;
#(
  parameter int N       = 32,
  parameter int CW      = 32,
  parameter bit TEST_EN = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_region,
  input  logic          start,
  input  logic          test,
  input  logic          restart,
  input  logic          adv_rise,
  input  logic          grant,
  input  logic [N-1:0]  region_in,
  input  logic          core_done,
  input  logic          core_test_valid,
  input  logic [CW-1:0] core_counter,
  input  logic [63:0]   core_cipher,
  output logic [2:0]    state,
  output logic [N-1:0]  core_region,
  output logic          core_start,
  output logic          core_restart,
  output logic          core_test_en,
  output logic          core_test_adv,
  output logic          pending,
  output logic [CW-1:0] res_counter,
  output logic [63:0]   res_cipher
);

  core_state_e   r_state;
  core_state_e   w_state_nxt;
  logic          w_go_run;
  logic          w_capture;
  logic          w_in_test;
  logic          w_tv_rise;
  logic          r_region_valid;
  logic          r_tv_prev;
  logic          r_start;
  logic          r_restart;
  logic          r_adv;
  logic          r_pending;
  logic [N-1:0]  r_region;
  logic [CW-1:0] r_counter;
  logic [63:0]   r_cipher;

  assign w_in_test = TEST_EN && (r_state == TEST);
  assign w_tv_rise = w_in_test && core_test_valid && !r_tv_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Restart has priority over everything, including a same-cycle done.
  always_comb begin
    w_state_nxt = r_state;
    w_go_run    = 1'b0;
    w_capture   = 1'b0;
    if (restart) begin
      w_state_nxt = IDLE;
    end else if (TEST_EN && test) begin
      w_state_nxt = TEST;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_region) w_state_nxt = READY;
        end
        READY: begin
          if (start && r_region_valid) begin
            w_state_nxt = RUN;
            w_go_run    = 1'b1;
          end
        end
        RUN: begin
          if (core_done) begin
            w_state_nxt = DONE;
            w_capture   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_region_valid <= 1'b0;
      r_tv_prev      <= 1'b0;
      r_start        <= 1'b0;
      r_restart      <= 1'b0;
      r_adv          <= 1'b0;
      r_pending      <= 1'b0;
      r_region       <= '0;
      r_counter      <= '0;
      r_cipher       <= '0;
    end else begin
      r_start   <= w_go_run;
      r_restart <= restart;
      r_adv     <= adv_rise && w_in_test && !restart;
      r_tv_prev <= core_test_valid;

      if (restart)          r_region_valid <= 1'b0;
      else if (load_region) r_region_valid <= 1'b1;

      // The region value survives a restart; only its valid flag is dropped.
      if (load_region && !restart) r_region <= region_in;

      if (w_capture || (w_in_test && !restart)) begin
        r_counter <= core_counter;
        r_cipher  <= core_cipher;
      end

      if (restart)                     r_pending <= 1'b0;
      else if (w_capture || w_tv_rise) r_pending <= 1'b1;
      else if (grant)                  r_pending <= 1'b0;
    end
  end

  assign state         = r_state;
  assign core_region   = r_region;
  assign core_start    = r_start;
  assign core_restart  = r_restart;
  assign core_test_en  = w_in_test;
  assign core_test_adv = r_adv;
  assign pending       = r_pending;
  assign res_counter   = r_counter;
  assign res_cipher    = r_cipher;

endmodule

`default_nettype wire

// File: rtl/des_multi_block_ctrl.sv
// ============================================================================
// Module : des_multi_block_ctrl
// Brief  : Command-driven controller for NUM_CORES DES search cores with a
//          round-robin result port. Optional test mode: DES_MULTI_TEST_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_multi_block_ctrl
  import des_multi_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int N         = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   cmd,
  input  logic                          cmd_valid_in,
  input  logic                          advance_test_in,
  input  logic [31:0]                   region,
  output logic                          cmd_read,
  output logic [31:0]                   cmd_read_data,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [NUM_CORES-1:0]          core_restart,
  output logic [NUM_CORES-1:0]          core_test_en,
  output logic [NUM_CORES-1:0]          core_test_adv,
  output logic [NUM_CORES*N-1:0]        core_region,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES-1:0]          core_test_valid,
  input  logic [NUM_CORES*des_cw(N)-1:0] core_counter,
  input  logic [NUM_CORES*64-1:0]       core_cipher,
  output logic                          res_valid,
  output logic [3:0]                    res_core,
  output logic [63:0]                   res_counter,
  output logic [63:0]                   res_cipher,
  input  logic                          res_ack
);

  localparam int CW = des_cw(N);

  logic r_valid_meta;
  logic r_valid_sync;
  logic w_adv_rise;
  logic w_unused_bits;

`ifdef DES_MULTI_TEST_EN
  localparam bit c_test_en = 1'b1;
  logic r_adv_meta;
  logic r_adv_sync;
  logic r_adv_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_adv_meta <= 1'b0;
      r_adv_sync <= 1'b0;
      r_adv_prev <= 1'b0;
    end else begin
      r_adv_meta <= advance_test_in;
      r_adv_sync <= r_adv_meta;
      r_adv_prev <= r_adv_sync;
    end
  end

  assign w_adv_rise = r_adv_sync && !r_adv_prev;
`else
  localparam bit c_test_en = 1'b0;
  assign w_adv_rise = 1'b0;
`endif

  assign w_unused_bits = ^{cmd[31:8], region, advance_test_in};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid_meta <= 1'b0;
      r_valid_sync <= 1'b0;
    end else begin
      r_valid_meta <= cmd_valid_in;
      r_valid_sync <= r_valid_meta;
    end
  end

  // Per-core status and strobes.
  logic [2:0]           w_core_state [NUM_CORES];
  logic [CW-1:0]        w_ch_counter [NUM_CORES];
  logic [63:0]          w_ch_cipher  [NUM_CORES];
  logic [NUM_CORES-1:0] w_pend;
  logic [NUM_CORES-1:0] w_ready;
  logic [NUM_CORES-1:0] w_busy;
  logic [NUM_CORES-1:0] w_sel;
  logic [NUM_CORES-1:0] w_load;
  logic [NUM_CORES-1:0] w_start;
  logic [NUM_CORES-1:0] w_test;
  logic [NUM_CORES-1:0] w_restart;
  logic [NUM_CORES-1:0] w_grant;

  logic [3:0] w_op;
  logic [3:0] w_idx;
  logic       w_idx_ok;

  assign w_op     = cmd[3:0];
  assign w_idx    = cmd[7:4];
  assign w_idx_ok = (int'(w_idx) < NUM_CORES);

  always_comb begin
    w_sel   = '0;
    w_ready = '0;
    w_busy  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_sel[i]   = (int'(w_idx) == i);
      w_ready[i] = (w_core_state[i] == READY);
      w_busy[i]  = (w_core_state[i] == RUN) || (w_core_state[i] == TEST) ||
                   (w_core_state[i] == DONE);
    end
  end

  // Command FSM.
  cmd_state_e  r_cmd_state;
  cmd_state_e  w_cmd_state_nxt;
  logic        w_accept;
  logic        w_reject;
  logic [31:0] w_read_data;
  logic [31:0] r_cmd_read_data;

  always_ff @(posedge clk) begin
    if (!rst_n) r_cmd_state <= C_IDLE;
    else        r_cmd_state <= w_cmd_state_nxt;
  end

  always_comb begin
    w_cmd_state_nxt = r_cmd_state;
    w_accept        = 1'b0;
    w_reject        = 1'b0;
    w_load          = '0;
    w_start         = '0;
    w_test          = '0;
    w_restart       = '0;
    case (r_cmd_state)
      C_IDLE: begin
        if (r_valid_sync) begin
          w_accept        = 1'b1;
          w_cmd_state_nxt = C_ACK;
          if (!w_idx_ok) begin
            w_reject = 1'b1;
          end else begin
            case (w_op)
              c_op_load_region: begin
                if (|(w_sel & w_busy)) w_reject = 1'b1;
                else                   w_load   = w_sel;
              end
              c_op_start: begin
                if (!(|(w_sel & w_ready))) w_reject = 1'b1;
                else                       w_start  = w_sel;
              end
              c_op_test: begin
                if (!c_test_en) w_reject = 1'b1;
                else            w_test   = w_sel;
              end
              c_op_restart:     w_restart = w_sel;
              c_op_start_all:   w_start   = w_ready;
              c_op_restart_all: w_restart = '1;
              default:          w_reject  = 1'b1;
            endcase
          end
        end
      end
      C_ACK: begin
        if (!r_valid_sync) w_cmd_state_nxt = C_IDLE;
      end
      default: w_cmd_state_nxt = C_IDLE;
    endcase
  end

  always_comb begin
    w_read_data               = {24'd0, cmd[7:0]};
    w_read_data[c_reject_bit] = w_reject;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        r_cmd_read_data <= '0;
    else if (w_accept) r_cmd_read_data <= w_read_data;
  end

  assign cmd_read      = (r_cmd_state == C_ACK);
  assign cmd_read_data = r_cmd_read_data;

  // Round-robin arbiter; a core being restarted this cycle is not granted.
  logic [NUM_CORES-1:0] w_pend_eff;
  logic                 w_found;
  logic                 w_can_load;
  logic [3:0]           w_gidx;
  logic [3:0]           r_last;
  logic [CW-1:0]        w_gnt_counter;
  logic [63:0]          w_gnt_cipher;
  int                   w_cand;

  assign w_pend_eff = w_pend & ~w_restart;
  assign w_can_load = !res_valid || res_ack;

  always_comb begin
    w_found       = 1'b0;
    w_gidx        = '0;
    w_cand        = 0;
    w_grant       = '0;
    w_gnt_counter = '0;
    w_gnt_cipher  = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      w_cand = int'(r_last) + k;
      if (w_cand >= NUM_CORES) w_cand = w_cand - NUM_CORES;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!w_found && (i == w_cand) && w_pend_eff[i]) begin
          w_found = 1'b1;
          w_gidx  = 4'(i);
        end
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_gidx == 4'(i)) begin
        w_grant[i]    = w_found && w_can_load;
        w_gnt_counter = w_ch_counter[i];
        w_gnt_cipher  = w_ch_cipher[i];
      end
    end
  end

  logic        r_res_valid;
  logic [3:0]  r_res_core;
  logic [63:0] r_res_counter;
  logic [63:0] r_res_cipher;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_valid   <= 1'b0;
      r_res_core    <= '0;
      r_res_counter <= '0;
      r_res_cipher  <= '0;
      r_last        <= 4'(NUM_CORES - 1);
    end else if (w_found && w_can_load) begin
      r_res_valid   <= 1'b1;
      r_res_core    <= w_gidx;
      r_res_counter <= {{N{1'b0}}, w_gnt_counter};
      r_res_cipher  <= w_gnt_cipher;
      r_last        <= w_gidx;
    end else if (res_ack) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid   = r_res_valid;
  assign res_core    = r_res_core;
  assign res_counter = r_res_counter;
  assign res_cipher  = r_res_cipher;

  generate
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      des_core_channel #(
        .N       (N),
        .CW      (CW),
        .TEST_EN (c_test_en)
      ) u_channel (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_region     (w_load[i]),
        .start           (w_start[i]),
        .test            (w_test[i]),
        .restart         (w_restart[i]),
        .adv_rise        (w_adv_rise),
        .grant           (w_grant[i]),
        .region_in       (region[N-1:0]),
        .core_done       (core_done[i]),
        .core_test_valid (core_test_valid[i]),
        .core_counter    (core_counter[i*CW +: CW]),
        .core_cipher     (core_cipher[i*64 +: 64]),
        .state           (w_core_state[i]),
        .core_region     (core_region[i*N +: N]),
        .core_start      (core_start[i]),
        .core_restart    (core_restart[i]),
        .core_test_en    (core_test_en[i]),
        .core_test_adv   (core_test_adv[i]),
        .pending         (w_pend[i]),
        .res_counter     (w_ch_counter[i]),
        .res_cipher      (w_ch_cipher[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_des_multi_block_ctrl.sv
// ============================================================================
// Module : tb_des_multi_block_ctrl
// Brief  : Directed self-checking bench for des_multi_block_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_des_multi_block_ctrl;

  localparam int NUM_CORES = 4;
  localparam int N         = 32;
  localparam int CW        = 64 - N;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [31:0]              cmd;
  logic                     cmd_valid_in;
  logic                     advance_test_in;
  logic [31:0]              region;
  logic                     cmd_read;
  logic [31:0]              cmd_read_data;
  logic [NUM_CORES-1:0]     core_start;
  logic [NUM_CORES-1:0]     core_restart;
  logic [NUM_CORES-1:0]     core_test_en;
  logic [NUM_CORES-1:0]     core_test_adv;
  logic [NUM_CORES*N-1:0]   core_region;
  logic [NUM_CORES-1:0]     core_done;
  logic [NUM_CORES-1:0]     core_test_valid;
  logic [NUM_CORES*CW-1:0]  core_counter;
  logic [NUM_CORES*64-1:0]  core_cipher;
  logic                     res_valid;
  logic [3:0]               res_core;
  logic [63:0]              res_counter;
  logic [63:0]              res_cipher;
  logic                     res_ack;

  int n_checks = 0;
  int n_errors = 0;

  des_multi_block_ctrl #(.NUM_CORES(NUM_CORES), .N(N)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd             (cmd),
    .cmd_valid_in    (cmd_valid_in),
    .advance_test_in (advance_test_in),
    .region          (region),
    .cmd_read        (cmd_read),
    .cmd_read_data   (cmd_read_data),
    .core_start      (core_start),
    .core_restart    (core_restart),
    .core_test_en    (core_test_en),
    .core_test_adv   (core_test_adv),
    .core_region     (core_region),
    .core_done       (core_done),
    .core_test_valid (core_test_valid),
    .core_counter    (core_counter),
    .core_cipher     (core_cipher),
    .res_valid       (res_valid),
    .res_core        (res_core),
    .res_counter     (res_counter),
    .res_cipher      (res_cipher),
    .res_ack         (res_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Full four-phase command; returns latency, echoed data and the pulses
  // seen in the first cmd_read cycle plus the start vector one cycle later.
  task automatic send_cmd(input logic [3:0] op, input logic [3:0] idx,
                          input logic [31:0] reg_v, output int lat,
                          output logic [31:0] rd, output logic [3:0] st,
                          output logic [3:0] rs, output logic [3:0] st_next);
    int wait_n;
    cmd          = {24'hABCDEF, idx, op};
    region       = reg_v;
    cmd_valid_in = 1'b1;
    lat          = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cmd_read && lat < 20);
    rd           = cmd_read_data;
    st           = core_start;
    rs           = core_restart;
    cmd_valid_in = 1'b0;
    @(negedge clk);
    st_next = core_start;
    wait_n  = 0;
    while (cmd_read && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    chk("hs_drop", {63'd0, cmd_read}, 64'd0);
  endtask

  int          lat;
  logic [31:0] rd;
  logic [3:0]  st, rs, st_n;
  int          n_adv;
  int          w;

  initial begin
    rst_n           = 1'b0;
    cmd             = '0;
    cmd_valid_in    = 1'b0;
    advance_test_in = 1'b0;
    region          = '0;
    core_done       = '0;
    core_test_valid = '0;
    core_counter    = '0;
    core_cipher     = '0;
    res_ack         = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_cmd_read",  {63'd0, cmd_read}, 64'd0);
    chk("rst_read_data", {32'd0, cmd_read_data}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_region",    core_region[63:0] | core_region[127:64], 64'd0);

    send_cmd(4'd1, 4'd2, 32'h5, lat, rd, st, rs, st_n);
    chk("load2_lat",    64'(lat), 64'd3);
    chk("load2_rd",     {32'd0, rd}, 64'h21);
    chk("load2_region", {32'd0, core_region[64 +: 32]}, 64'h5);

    send_cmd(4'd2, 4'd2, 32'h0, lat, rd, st, rs, st_n);
    chk("start2_rd",    {32'd0, rd}, 64'h22);
    chk("start2_pulse", {60'd0, st}, 64'b0100);
    chk("start2_once",  {60'd0, st_n}, 64'd0);

    send_cmd(4'd2, 4'd1, 32'h0, lat, rd, st, rs, st_n);
    chk("start1_rej",   {32'd0, rd}, 64'h8000_0012);
    chk("start1_nopls", {60'd0, st}, 64'd0);

    send_cmd(4'd1, 4'd7, 32'h9, lat, rd, st, rs, st_n);
    chk("idx7_rej", {32'd0, rd}, 64'h8000_0071);
    send_cmd(4'd9, 4'd0, 32'h0, lat, rd, st, rs, st_n);
    chk("op9_rej",  {32'd0, rd}, 64'h8000_0009);
`ifndef DES_MULTI_TEST_EN
    send_cmd(4'd3, 4'd0, 32'h0, lat, rd, st, rs, st_n);
    chk("test_rej", {32'd0, rd}, 64'h8000_0003);
`endif

    send_cmd(4'd1, 4'd2, 32'h99, lat, rd, st, rs, st_n);
    chk("load_run_rej", {32'd0, rd}, 64'h8000_0021);
    chk("load_run_keep", {32'd0, core_region[64 +: 32]}, 64'h5);

    send_cmd(4'd1, 4'd0, 32'h10, lat, rd, st, rs, st_n);
    send_cmd(4'd1, 4'd3, 32'h30, lat, rd, st, rs, st_n);
    send_cmd(4'd5, 4'd0, 32'h0, lat, rd, st, rs, st_n);
    chk("start_all_rd",    {32'd0, rd}, 64'h05);
    chk("start_all_pulse", {60'd0, st}, 64'b1001);

    // Cores 0 and 3 finish together.
    core_counter[0 +: 32]   = 32'hA;
    core_counter[96 +: 32]  = 32'hB;
    core_cipher[0 +: 64]    = 64'h0123_4567_89AB_CDEF;
    core_cipher[192 +: 64]  = 64'hFEDC_BA98_7654_3210;
    core_done               = 4'b1001;
    @(negedge clk);
    chk("done_lat1", {63'd0, res_valid}, 64'd0);
    @(negedge clk);
    chk("res0_valid",   {63'd0, res_valid}, 64'd1);
    chk("res0_core",    {60'd0, res_core}, 64'd0);
    chk("res0_counter", res_counter, 64'hA);
    chk("res0_cipher",  res_cipher, 64'h0123_4567_89AB_CDEF);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    chk("res3_valid",   {63'd0, res_valid}, 64'd1);
    chk("res3_core",    {60'd0, res_core}, 64'd3);
    chk("res3_counter", res_counter, 64'hB);
    chk("res3_cipher",  res_cipher, 64'hFEDC_BA98_7654_3210);
    @(negedge clk);
    chk("res3_hold", {63'd0, res_valid}, 64'd1);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    chk("res_drain", {63'd0, res_valid}, 64'd0);
    core_done = '0;

    // Restart core 1 in the very cycle it reports done.
    send_cmd(4'd1, 4'd1, 32'h77, lat, rd, st, rs, st_n);
    send_cmd(4'd2, 4'd1, 32'h0, lat, rd, st, rs, st_n);
    chk("start1_pulse", {60'd0, st}, 64'b0010);
    cmd          = {24'h0, 4'd1, 4'd4};
    cmd_valid_in = 1'b1;
    repeat (2) @(negedge clk);
    core_done[1] = 1'b1;
    @(negedge clk);
    chk("rst_done_read",  {63'd0, cmd_read}, 64'd1);
    chk("rst_done_pulse", {60'd0, core_restart}, 64'b0010);
    chk("rst_done_rd",    {32'd0, cmd_read_data}, 64'h14);
    cmd_valid_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_done_nores", {63'd0, res_valid}, 64'd0);
    core_done = '0;
    send_cmd(4'd2, 4'd1, 32'h0, lat, rd, st, rs, st_n);
    chk("core1_idle",   {32'd0, rd}, 64'h8000_0012);
    chk("core1_region", {32'd0, core_region[32 +: 32]}, 64'h77);

    send_cmd(4'd6, 4'd0, 32'h0, lat, rd, st, rs, st_n);
    chk("restart_all_rd",    {32'd0, rd}, 64'h06);
    chk("restart_all_pulse", {60'd0, rs}, 64'b1111);

`ifdef DES_MULTI_TEST_EN
    send_cmd(4'd3, 4'd0, 32'h0, lat, rd, st, rs, st_n);
    chk("test_rd", {32'd0, rd}, 64'h03);
    chk("test_en", {60'd0, core_test_en}, 64'b0001);
    n_adv = 0;
    for (int t = 0; t < 3; t++) begin
      advance_test_in = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (core_test_adv[0]) n_adv++;
      end
      advance_test_in = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (core_test_adv[0]) n_adv++;
      end
      core_counter[0 +: 32] = 32'h100 + 32'(t);
      core_test_valid[0]    = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!res_valid && w < 6);
      chk("test_res_valid", {63'd0, res_valid}, 64'd1);
      chk("test_res_cnt",   res_counter, 64'h100 + 64'(t));
      res_ack = 1'b1;
      @(negedge clk);
      res_ack            = 1'b0;
      core_test_valid[0] = 1'b0;
      @(negedge clk);
    end
    chk("test_adv_count", 64'(n_adv), 64'd3);
`endif

    // Reset in the middle of a handshake.
    cmd          = {24'h0, 4'd0, 4'd1};
    region       = 32'h55;
    cmd_valid_in = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!cmd_read && w < 20);
    chk("mid_read_up", {63'd0, cmd_read}, 64'd1);
    rst_n        = 1'b0;
    cmd_valid_in = 1'b0;
    @(negedge clk);
    chk("mid_rst_read",   {63'd0, cmd_read}, 64'd0);
    chk("mid_rst_rd",     {32'd0, cmd_read_data}, 64'd0);
    chk("mid_rst_region", core_region[63:0] | core_region[127:64], 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send_cmd(4'd1, 4'd1, 32'h7, lat, rd, st, rs, st_n);
    chk("post_rst_lat",    64'(lat), 64'd3);
    chk("post_rst_rd",     {32'd0, rd}, 64'h11);
    chk("post_rst_region", {32'd0, core_region[32 +: 32]}, 64'h7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
